swci_uart_bridge: RTL and testbench
===================================

// Module: swci_uart_bridge
// PURPOSE
//  Parametrised multi-channel simulation bridge between host-side testbench code and NUM_CH DUT UART FIFOs.
//  TX: taps each DUT TX-FIFO write port, buffers bytes per channel, round-robins them into one tagged host stream.
//  RX: accepts tagged host bytes, queues them per channel, paces injection into the DUT RX FIFOs under rx-full backpressure.
//  Sits in the Verilator top, between the C++ harness and the subsystem hierarchy.
// PARAMETERS
//  NUM_CH   4  number of UART channels (1..16); CHW = max(1,$clog2(NUM_CH)) localparam
//  DW       8  byte width
//  TX_DEPTH 16 per-channel TX capture FIFO entries (power of 2, >=2)
//  RX_DEPTH 8  per-channel RX injection queue entries (power of 2, >=2)
//  INJ_GAP  2  minimum idle cycles between injections on one channel (0 = back-to-back)
// PORTS
//  sysclk_i         in  1          clock
//  rst_i            in  1          synchronous reset, active-high
//  dut_tx_wr_i      in  NUM_CH     DUT TX-FIFO write strobe per channel
//  dut_tx_data_i    in  NUM_CH*DW  DUT TX-FIFO write data, channel c at [c*DW +: DW]
//  dut_rx_full_i    in  NUM_CH     DUT RX-FIFO full per channel
//  dut_rx_wr_o      out NUM_CH     RX-FIFO write pulse per channel
//  dut_rx_data_o    out NUM_CH*DW  RX-FIFO write data per channel
//  host_tx_valid_o  out 1          captured byte available
//  host_tx_ready_i  in  1          host accepts byte
//  host_tx_data_o   out DW         captured byte
//  host_tx_ch_o     out CHW        source channel of host_tx_data_o
//  host_tx_ts_o     out 32         capture cycle stamp (only with SWCI_UART_TIMESTAMP_EN)
//  host_rx_valid_i  in  1          host byte offered
//  host_rx_ready_o  out 1          bridge accepts host byte
//  host_rx_data_i   in  DW         byte to inject
//  host_rx_ch_i     in  CHW        destination channel
//  ovf_o            out NUM_CH     sticky TX capture overflow per channel
// BEHAVIOUR
//  Reset (sync, rst_i=1 at posedge): all FIFOs/queues emptied, gap counters 0, RR pointer 0; every output 0 except host_rx_ready_o.
//   host_rx_ready_o is combinational and reads 1 during and after reset, since all queues are empty.
//  Reset mid-operation discards all buffered bytes; an in-flight host_tx byte is lost.
//  TX capture: dut_tx_wr_i[c]=1 pushes that channel's data slice into FIFO c.
//   Full is evaluated before any same-cycle pop; a push to a full FIFO is dropped and sets ovf_o[c].
//   ovf_o[c] holds until reset.
//  TX arbiter: one output holding register.
//   Loads when empty, or when a transfer (valid&&ready) completes the same cycle; no bubble under continuous ready.
//   Grant is round-robin, starting from the channel after the last granted one.
//   The grant pops that FIFO and loads data/ch(/ts).
//  TX latency: dut_tx_wr_i at cycle N -> host_tx_valid_o high at N+2 at the earliest.
//  host_tx_valid_o/data/ch stay stable while ready=0.
//  RX accept: host_rx_ready_o = !full(queue[host_rx_ch_i]), combinational, independent of same-cycle pops.
//   host_rx_ch_i >= NUM_CH: ready=1, byte discarded.
//  RX injector per channel, states IDLE/GAP:
//   IDLE + queue non-empty + !dut_rx_full_i[c] -> registered pulse: dut_rx_wr_o[c]=1 for exactly one cycle, byte on dut_rx_data_o[c], pop.
//    Go to GAP with count = INJ_GAP; if INJ_GAP=0, stay IDLE.
//   GAP decrements each cycle; returns to IDLE on reaching 0.
//   dut_rx_full_i high stalls in IDLE, with no pulse.
//   dut_rx_data_o holds the last injected byte.
//  Bytes are never reordered within a channel on either path.
// CONFIGURATION
//  SWCI_UART_TIMESTAMP_EN defined:
//   Free-running 32-bit cycle counter, 0 at reset, wraps at 2^32-1 -> 0.
//   Each TX FIFO entry stores the counter value at push; the stamp is presented on host_tx_ts_o with the byte.
//  Not defined: no counter, FIFO width DW, port host_tx_ts_o absent.
// TESTING
//  T1 reset: assert rst_i 2 cycles with traffic active -> all outputs 0, host_rx_ready_o=1, ovf_o=0, no stale byte after release.
//  T2 single byte: ch1 writes 8'h41 at cycle N, ready=1 -> host valid at N+2, data 8'h41, ch 1, held stable while ready=0 for 5 cycles.
//  T3 fairness: ch0..3 each write 4 bytes the same cycles -> output order ch0,1,2,3 repeated 4x, no idle cycles under continuous ready.
//  T4 overflow: ch2 writes 17 bytes with ready=0 (TX_DEPTH 16) -> 17th dropped, ovf_o=4'b0100, first 16 bytes delivered in order.
//  T5 RX pacing: host pushes 'a','b','c' to ch0, INJ_GAP=2 -> dut_rx_wr_o[0] pulses 3 cycles apart, data 'a','b','c';
//     dut_rx_full_i[0] held high 10 cycles mid-stream -> no pulse during that window, then resume; ninth push to full queue sees ready=0.
//  T6 TIMESTAMP_EN: bytes captured at cycles 100 and 105 after reset -> host_tx_ts_o 100 and 105; preset counter near wrap -> ts rolls to 0.

Source files
------------

// File: rtl/swci_uart_bridge_if.sv
// Host-side tagged byte streams of the UART bridge.
// Optional host_tx_ts exists only when SWCI_UART_TIMESTAMP_EN is defined.
interface swci_uart_bridge_if #(
   parameter int DW  = 8,
   parameter int CHW = 2
);
   logic           host_tx_valid;
   logic           host_tx_ready;
   logic [DW-1:0]  host_tx_data;
   logic [CHW-1:0] host_tx_ch;
`ifdef SWCI_UART_TIMESTAMP_EN
   logic [31:0]    host_tx_ts;
`endif
   logic           host_rx_valid;
   logic           host_rx_ready;
   logic [DW-1:0]  host_rx_data;
   logic [CHW-1:0] host_rx_ch;

   modport master (
      output host_tx_valid, host_tx_data, host_tx_ch,
`ifdef SWCI_UART_TIMESTAMP_EN
      output host_tx_ts,
`endif
      input  host_tx_ready,
      input  host_rx_valid, host_rx_data, host_rx_ch,
      output host_rx_ready
   );

   modport slave (
      input  host_tx_valid, host_tx_data, host_tx_ch,
`ifdef SWCI_UART_TIMESTAMP_EN
      input  host_tx_ts,
`endif
      output host_tx_ready,
      output host_rx_valid, host_rx_data, host_rx_ch,
      input  host_rx_ready
   );
endinterface

// File: rtl/swci_uart_bridge.sv
// Multi-channel UART simulation bridge: TX capture + round-robin to host, RX queue + paced injection.
// Optional feature macro: SWCI_UART_TIMESTAMP_EN (32-bit capture stamp per TX byte).
module swci_uart_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full_o,
   output logic         empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [W-1:0] mem_d [DEPTH];
   logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;

   // Extra pointer bit distinguishes full from empty.
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign dout    = mem_q[rptr_q[AW-1:0]];

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push && !full_o) begin
         mem_d[wptr_q[AW-1:0]] = din;
         wptr_d = wptr_q + 1'b1;
      end
      if (pop && !empty_o) rptr_d = rptr_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end
endmodule

module swci_uart_rx_lane #(
   parameter int DW      = 8,
   parameter int DEPTH   = 8,
   parameter int INJ_GAP = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] din,
   output logic          full_o,
   input  logic          dut_full_i,
   output logic          wr_o,
   output logic [DW-1:0] data_o
);
   localparam int GW = (INJ_GAP > 0) ? $clog2(INJ_GAP + 1) : 1;

   typedef enum logic {S_IDLE, S_GAP} inj_state_e;

   inj_state_e    state_q, state_d;
   logic [GW-1:0] cnt_q, cnt_d;
   logic          wr_q, wr_d;
   logic [DW-1:0] data_q, data_d;
   logic          empty, pop;
   logic [DW-1:0] head;

   swci_uart_fifo #(.W(DW), .DEPTH(DEPTH)) u_q (
      .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
      .dout(head), .full_o(full_o), .empty_o(empty)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wr_d    = 1'b0;
      data_d  = data_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: if (!empty && !dut_full_i) begin
            wr_d   = 1'b1;
            data_d = head;
            pop    = 1'b1;
            if (INJ_GAP != 0) begin
               state_d = S_GAP;
               cnt_d   = GW'(INJ_GAP);
            end
         end
         S_GAP: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == GW'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         wr_q    <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
      end
   end

   assign wr_o   = wr_q;
   assign data_o = data_q;
endmodule

module swci_uart_bridge #(
   parameter int NUM_CH   = 4,
   parameter int DW       = 8,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 8,
   parameter int INJ_GAP  = 2
) (
   input  logic                 sysclk_i,
   input  logic                 rst_i,
   input  logic [NUM_CH-1:0]    dut_tx_wr_i,
   input  logic [NUM_CH*DW-1:0] dut_tx_data_i,
   input  logic [NUM_CH-1:0]    dut_rx_full_i,
   output logic [NUM_CH-1:0]    dut_rx_wr_o,
   output logic [NUM_CH*DW-1:0] dut_rx_data_o,
   output logic [NUM_CH-1:0]    ovf_o,
   swci_uart_bridge_if.master   host
);
   localparam int CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
`ifdef SWCI_UART_TIMESTAMP_EN
   localparam int TXW = DW + 32;
`else
   localparam int TXW = DW;
`endif

   logic [NUM_CH-1:0]          tx_full, tx_empty, tx_pop, rx_full, rx_push;
   logic [NUM_CH-1:0][TXW-1:0] tx_din, tx_dout;
   logic [NUM_CH-1:0]          ovf_q, ovf_d;
   logic                       vld_q, vld_d;
   logic [DW-1:0]              data_q, data_d;
   logic [CHW-1:0]             ch_q, ch_d, rr_q, rr_d, gnt, cand;
   logic                       load, gnt_ok, sel_full;
   int                         idx;
`ifdef SWCI_UART_TIMESTAMP_EN
   logic [31:0]                ts_q, ts_d, stamp_q, stamp_d;
`endif

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef SWCI_UART_TIMESTAMP_EN
      assign tx_din[c] = {ts_q, dut_tx_data_i[c*DW +: DW]};
`else
      assign tx_din[c] = dut_tx_data_i[c*DW +: DW];
`endif
      swci_uart_fifo #(.W(TXW), .DEPTH(TX_DEPTH)) u_tx_fifo (
         .clk(sysclk_i), .rst(rst_i), .push(dut_tx_wr_i[c]), .din(tx_din[c]),
         .pop(tx_pop[c]), .dout(tx_dout[c]), .full_o(tx_full[c]), .empty_o(tx_empty[c])
      );

      assign rx_push[c] = host.host_rx_valid && (host.host_rx_ch == CHW'(c)) && !rx_full[c];

      swci_uart_rx_lane #(.DW(DW), .DEPTH(RX_DEPTH), .INJ_GAP(INJ_GAP)) u_rx_lane (
         .clk(sysclk_i), .rst(rst_i), .push(rx_push[c]), .din(host.host_rx_data),
         .full_o(rx_full[c]), .dut_full_i(dut_rx_full_i[c]),
         .wr_o(dut_rx_wr_o[c]), .data_o(dut_rx_data_o[c*DW +: DW])
      );
   end

   // Out-of-range channels match no lane, so they read ready and are dropped.
   always_comb begin
      sel_full = 1'b0;
      for (int c = 0; c < NUM_CH; c++)
         if (host.host_rx_ch == CHW'(c)) sel_full = rx_full[c];
   end
   assign host.host_rx_ready = !sel_full;

   always_comb begin
      ovf_d  = ovf_q | (dut_tx_wr_i & tx_full);
      load   = !vld_q || host.host_tx_ready;
      gnt_ok = 1'b0;
      gnt    = '0;
      idx    = 0;
      cand   = '0;
      // rr_q names the first channel to consider this cycle.
      for (int i = 0; i < NUM_CH; i++) begin
         idx = int'(rr_q) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         cand = CHW'(idx);
         if (!gnt_ok && !tx_empty[cand]) begin
            gnt_ok = 1'b1;
            gnt    = cand;
         end
      end
      tx_pop = '0;
      vld_d  = vld_q;
      data_d = data_q;
      ch_d   = ch_q;
      rr_d   = rr_q;
`ifdef SWCI_UART_TIMESTAMP_EN
      stamp_d = stamp_q;
      ts_d    = ts_q + 32'd1;
`endif
      if (load) begin
         vld_d = gnt_ok;
         if (gnt_ok) begin
            tx_pop[gnt] = 1'b1;
            data_d      = tx_dout[gnt][DW-1:0];
            ch_d        = gnt;
            rr_d        = (gnt == CHW'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
`ifdef SWCI_UART_TIMESTAMP_EN
            stamp_d     = tx_dout[gnt][TXW-1:DW];
`endif
         end
      end
   end

   always_ff @(posedge sysclk_i) begin
      if (rst_i) begin
         ovf_q   <= '0;
         vld_q   <= 1'b0;
         data_q  <= '0;
         ch_q    <= '0;
         rr_q    <= '0;
`ifdef SWCI_UART_TIMESTAMP_EN
         stamp_q <= '0;
         ts_q    <= '0;
`endif
      end else begin
         ovf_q   <= ovf_d;
         vld_q   <= vld_d;
         data_q  <= data_d;
         ch_q    <= ch_d;
         rr_q    <= rr_d;
`ifdef SWCI_UART_TIMESTAMP_EN
         stamp_q <= stamp_d;
         ts_q    <= ts_d;
`endif
      end
   end

   assign ovf_o              = ovf_q;
   assign host.host_tx_valid = vld_q;
   assign host.host_tx_data  = data_q;
   assign host.host_tx_ch    = ch_q;
`ifdef SWCI_UART_TIMESTAMP_EN
   assign host.host_tx_ts    = stamp_q;
`endif
endmodule

// File: tb/tb_swci_uart_bridge.sv
// Scoreboard bench for swci_uart_bridge: stimulus queues expected bytes, a negedge monitor checks them.
module tb_swci_uart_bridge;
   localparam int NUM_CH = 4, DW = 8, CHW = 2;

   logic        sysclk = 1'b0;
   logic        rst    = 1'b1;
   logic [3:0]  dut_tx_wr   = '0;
   logic [31:0] dut_tx_data = '0;
   logic [3:0]  dut_rx_full = '0;
   logic [3:0]  dut_rx_wr;
   logic [31:0] dut_rx_data;
   logic [3:0]  ovf;

   swci_uart_bridge_if #(.DW(DW), .CHW(CHW)) hif ();

   swci_uart_bridge #(.NUM_CH(NUM_CH), .DW(DW), .TX_DEPTH(16), .RX_DEPTH(8), .INJ_GAP(2)) dut (
      .sysclk_i(sysclk), .rst_i(rst),
      .dut_tx_wr_i(dut_tx_wr), .dut_tx_data_i(dut_tx_data),
      .dut_rx_full_i(dut_rx_full), .dut_rx_wr_o(dut_rx_wr), .dut_rx_data_o(dut_rx_data),
      .ovf_o(ovf), .host(hif.master)
   );

   always #5 sysclk = ~sysclk;

   int errors = 0, checks = 0, cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   logic [CHW+DW-1:0] tx_exp[$];
   logic [CHW+DW-1:0] rx_exp[$];
   int                pulse_t[$];
   int                xfer_t[$];
   logic              hold_pend = 1'b0;
   logic [CHW+DW-1:0] hold_v;
   logic [3:0]        full_prev = '0;
`ifdef SWCI_UART_TIMESTAMP_EN
   logic [31:0] ts_exp[$];
   logic [31:0] tb_ts = '0;
   always @(posedge sysclk) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;
`endif

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name, input logic [63:0] act);
      checks++;
      errors++;
      $display("FAIL %s: got output %0h expected none (cycle %0d)", name, act, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while ((tx_exp.size() != 0 || rx_exp.size() != 0) && k < budget) begin
         @(posedge sysclk);
         k++;
      end
      #1;
      chk(name, 64'(k < budget), 64'd1);
   endtask

   task automatic rx_push(input logic [7:0] d, input logic exp_rdy);
      hif.host_rx_valid = 1'b1;
      hif.host_rx_ch    = 2'd0;
      hif.host_rx_data  = d;
      #1;
      chk("rx_ready", 64'(hif.host_rx_ready), 64'(exp_rdy));
      if (exp_rdy) rx_exp.push_back({2'd0, d});
      tick(1);
   endtask

   // Monitor: sample at negedge, where inputs and outputs are settled for the coming edge.
   always @(negedge sysclk) begin
      if (!rst) begin
         if (hold_pend && hif.host_tx_valid)
            chk("tx_hold", 64'({hif.host_tx_ch, hif.host_tx_data}), 64'(hold_v));
         if (hif.host_tx_valid && hif.host_tx_ready) begin
            xfer_t.push_back(cyc);
            if (tx_exp.size() == 0) unexpected("tx_unexpected", 64'({hif.host_tx_ch, hif.host_tx_data}));
            else chk("tx_data", 64'({hif.host_tx_ch, hif.host_tx_data}), 64'(tx_exp.pop_front()));
`ifdef SWCI_UART_TIMESTAMP_EN
            if (ts_exp.size() != 0) chk("tx_ts", 64'(hif.host_tx_ts), 64'(ts_exp.pop_front()));
`endif
         end
         hold_pend = hif.host_tx_valid && !hif.host_tx_ready;
         hold_v    = {hif.host_tx_ch, hif.host_tx_data};
         for (int c = 0; c < NUM_CH; c++) begin
            if (dut_rx_wr[c]) begin
               chk("rx_stall", 64'(full_prev[c]), 64'd0);
               if (rx_exp.size() == 0) unexpected("rx_unexpected", 64'(dut_rx_data[c*8 +: 8]));
               else chk("rx_data", 64'({2'(c), dut_rx_data[c*8 +: 8]}), 64'(rx_exp.pop_front()));
               if (c == 0) pulse_t.push_back(cyc);
            end
         end
      end else begin
         hold_pend = 1'b0;
      end
      full_prev = dut_rx_full;
   end

   initial begin
      int n0;
      hif.host_tx_ready = 1'b0;
      hif.host_rx_valid = 1'b0;
      hif.host_rx_ch    = '0;
      hif.host_rx_data  = '0;
      tick(2);
      rst = 1'b0;

      // T1: fill ch3 past capacity, then reset with traffic on both paths.
      for (int i = 0; i < 20; i++) begin
         dut_tx_wr = 4'b1000; dut_tx_data = {8'(8'h80 + i), 24'h0};
         tick(1);
      end
      dut_tx_wr = '0;
      chk("t1_ovf_pre", 64'(ovf), 64'h8);
      rst = 1'b1;
      dut_tx_wr = 4'b1111; dut_tx_data = 32'hDEADBEEF;
      hif.host_rx_valid = 1'b1; hif.host_rx_ch = 2'd1; hif.host_rx_data = 8'h55;
      tick(1);
      chk("t1_tx_valid", 64'(hif.host_tx_valid), 64'd0);
      chk("t1_tx_data", 64'({hif.host_tx_ch, hif.host_tx_data}), 64'd0);
      chk("t1_ovf", 64'(ovf), 64'd0);
      chk("t1_rx_wr", 64'(dut_rx_wr), 64'd0);
      chk("t1_rx_data", 64'(dut_rx_data), 64'd0);
      chk("t1_rx_ready", 64'(hif.host_rx_ready), 64'd1);
      tick(1);
      rst = 1'b0; dut_tx_wr = '0; hif.host_rx_valid = 1'b0;
      hif.host_tx_ready = 1'b1;
      tick(6);
      chk("t1_no_stale", 64'(hif.host_tx_valid), 64'd0);

      // T2: single byte latency and hold under ready=0.
      hif.host_tx_ready = 1'b0;
      dut_tx_wr = 4'b0010; dut_tx_data = 32'h0000_4100;
      tx_exp.push_back({2'd1, 8'h41});
      tick(1);
      dut_tx_wr = '0;
      chk("t2_valid_n1", 64'(hif.host_tx_valid), 64'd0);
      tick(1);
      chk("t2_valid_n2", 64'(hif.host_tx_valid), 64'd1);
      chk("t2_data_n2", 64'({hif.host_tx_ch, hif.host_tx_data}), 64'({2'd1, 8'h41}));
      tick(5);
      hif.host_tx_ready = 1'b1;
      wait_drain("t2_drain", 20);

      // T3: fairness from a fresh round-robin pointer.
      rst = 1'b1; tick(1); rst = 1'b0;
      xfer_t.delete();
      for (int k = 0; k < 4; k++) begin
         dut_tx_wr = 4'b1111;
         dut_tx_data = {8'(8'h40 + k), 8'(8'h30 + k), 8'(8'h20 + k), 8'(8'h10 + k)};
         for (int c = 0; c < 4; c++) tx_exp.push_back({2'(c), 8'((c + 1) * 16 + k)});
         tick(1);
      end
      dut_tx_wr = '0;
      wait_drain("t3_drain", 40);
      chk("t3_count", 64'(xfer_t.size()), 64'd16);
      if (xfer_t.size() == 16) chk("t3_no_bubble", 64'(xfer_t[15] - xfer_t[0]), 64'd15);

      // T4: holding register busy with a ch0 byte, so ch2's FIFO takes exactly 16.
      hif.host_tx_ready = 1'b0;
      dut_tx_wr = 4'b0001; dut_tx_data = 32'h0000_00C0;
      tx_exp.push_back({2'd0, 8'hC0});
      tick(1);
      dut_tx_wr = '0;
      tick(2);
      for (int i = 0; i < 17; i++) begin
         if (i == 16) chk("t4_ovf_pre", 64'(ovf), 64'd0);
         dut_tx_wr = 4'b0100; dut_tx_data = {8'h0, 8'(8'h60 + i), 16'h0};
         if (i < 16) tx_exp.push_back({2'd2, 8'(8'h60 + i)});
         tick(1);
      end
      dut_tx_wr = '0;
      chk("t4_ovf", 64'(ovf), 64'h4);
      hif.host_tx_ready = 1'b1;
      wait_drain("t4_drain", 40);
      chk("t4_ovf_sticky", 64'(ovf), 64'h4);

      // T5: RX pacing, stall under dut_rx_full, queue-full backpressure.
      pulse_t.delete();
      rx_push(8'h61, 1'b1); rx_push(8'h62, 1'b1); rx_push(8'h63, 1'b1);
      hif.host_rx_valid = 1'b0;
      wait_drain("t5_drain_abc", 30);
      chk("t5_pulses", 64'(pulse_t.size()), 64'd3);
      if (pulse_t.size() == 3) begin
         chk("t5_gap1", 64'(pulse_t[1] - pulse_t[0]), 64'd3);
         chk("t5_gap2", 64'(pulse_t[2] - pulse_t[1]), 64'd3);
      end
      rx_push(8'h64, 1'b1); rx_push(8'h65, 1'b1); rx_push(8'h66, 1'b1); rx_push(8'h67, 1'b1);
      hif.host_rx_valid = 1'b0;
      dut_rx_full = 4'b0001;
      tick(1);
      n0 = pulse_t.size();
      tick(9);
      dut_rx_full = '0;
      tick(1);
      chk("t5_stall_window", 64'(pulse_t.size()), 64'(n0));
      wait_drain("t5_drain_defg", 30);
      dut_rx_full = 4'b0001;
      for (int i = 0; i < 8; i++) rx_push(8'(8'h30 + i), 1'b1);
      rx_push(8'h38, 1'b0);
      hif.host_rx_valid = 1'b0;
      dut_rx_full = '0;
      wait_drain("t5_drain_full", 60);

`ifdef SWCI_UART_TIMESTAMP_EN
      // T6: capture stamps at counter values 100 and 105.
      rst = 1'b1; tick(1); rst = 1'b0;
      for (int k = 0; k < 200 && tb_ts != 32'd100; k++) tick(1);
      dut_tx_wr = 4'b0001; dut_tx_data = 32'h0000_00A0;
      tx_exp.push_back({2'd0, 8'hA0}); ts_exp.push_back(32'd100);
      tick(1);
      dut_tx_wr = '0;
      for (int k = 0; k < 20 && tb_ts != 32'd105; k++) tick(1);
      dut_tx_wr = 4'b0001; dut_tx_data = 32'h0000_00A5;
      tx_exp.push_back({2'd0, 8'hA5}); ts_exp.push_back(32'd105);
      tick(1);
      dut_tx_wr = '0;
      wait_drain("t6_drain", 20);
`endif

      tick(4);
      chk("end_tx_queue", 64'(tx_exp.size()), 64'd0);
      chk("end_rx_queue", 64'(rx_exp.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
